// File: rtl/ps2_key_sequencer.sv
// PS/2 key sequencer: frames a typing session between start/end keys, filters
// break (F0) and extended (E0) prefixes, and queues translated characters in a FWFT FIFO.
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] scan_code,
    input  logic       valido,
    input  logic       iniciar,
    input  logic       terminar,
    input  logic [6:0] traduccion,
    output logic       rx_en,
    output logic [6:0] char_out,
    output logic       char_empty,
    output logic       char_full,
    input  logic       char_rd,
    output logic       session_active,
    output logic       session_done,
    output logic       overflow,
    output logic [7:0] char_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    SC_BREAK   = 8'hF0;
    localparam logic [7:0]    SC_EXTEND  = 8'hE0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BRK_I,
        S_ACTIVE,
        S_BRK_A,
        S_EXT,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [TW-1:0]   tmo_cnt_reg;
    logic            session_active_reg;
    logic            session_done_reg;
    logic            rx_en_reg;
    logic            overflow_reg;
    logic [7:0]      char_count_reg;
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic [6:0]      mem [FIFO_DEPTH];

    logic is_break;
    logic is_extend;
    logic tmo_hit;
    logic start_session;
    logic push_req;
    logic do_push;
    logic do_pop;
    logic fifo_empty;
    logic fifo_full;

    always_comb begin
        is_break      = (scan_code == SC_BREAK);
        is_extend     = (scan_code == SC_EXTEND);
        tmo_hit       = (tmo_cnt_reg == TMO_LAST);
        start_session = rx_done_tick && (state_reg == S_IDLE) && !is_break && iniciar;
        // Priority inside a session: F0, E0, end key, start key, then translatable byte.
        push_req      = rx_done_tick && (state_reg == S_ACTIVE) && !is_break && !is_extend
                        && !terminar && !iniciar && valido;
        fifo_empty    = (wr_ptr_reg == rd_ptr_reg);
        fifo_full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW])
                        && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
        do_pop        = char_rd && !fifo_empty;
        // A pop on the same edge frees the slot, so a full FIFO can still accept.
        do_push       = push_req && (!fifo_full || do_pop);
    end

    // Session state machine. The prefix counter idles at zero and only runs
    // while sitting in BRK_I, BRK_A or EXT without a new byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg          <= S_IDLE;
            tmo_cnt_reg        <= '0;
            session_active_reg <= 1'b0;
            session_done_reg   <= 1'b0;
        end else begin
            tmo_cnt_reg      <= '0;
            session_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (rx_done_tick) begin
                        if (is_break) begin
                            state_reg <= S_BRK_I;
                        end else if (iniciar) begin
                            state_reg          <= S_ACTIVE;
                            session_active_reg <= 1'b1;
                        end
                    end
                end
                S_BRK_I: begin
                    if (rx_done_tick || tmo_hit) begin
                        state_reg <= S_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (rx_done_tick) begin
                        if (is_break) begin
                            state_reg <= S_BRK_A;
                        end else if (is_extend) begin
                            state_reg <= S_EXT;
                        end else if (terminar) begin
                            state_reg          <= S_DONE;
                            session_active_reg <= 1'b0;
                            session_done_reg   <= 1'b1;
                        end
                    end
                end
                S_BRK_A: begin
                    if (rx_done_tick || tmo_hit) begin
                        state_reg <= S_ACTIVE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_done_tick) begin
                        state_reg <= is_break ? S_BRK_A : S_ACTIVE;
                    end else if (tmo_hit) begin
                        state_reg <= S_ACTIVE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg          <= S_IDLE;
                    session_active_reg <= 1'b0;
                end
            endcase
        end
    end

    // FIFO bookkeeping; a session start discards whatever the previous one left behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            overflow_reg   <= 1'b0;
            char_count_reg <= '0;
        end else if (start_session) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            overflow_reg   <= 1'b0;
            char_count_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (char_count_reg != 8'hFF) begin
                    char_count_reg <= char_count_reg + 8'd1;
                end
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_req && !do_push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= traduccion;
        end
    end

    // Receiver enable follows the full flag one cycle late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_en_reg <= 1'b0;
        end else begin
            rx_en_reg <= ~fifo_full;
        end
    end

    assign rx_en          = rx_en_reg;
    assign char_out       = fifo_empty ? 7'd0 : mem[rd_ptr_reg[AW-1:0]];
    assign char_empty     = fifo_empty;
    assign char_full      = fifo_full;
    assign session_active = session_active_reg;
    assign session_done   = session_done_reg;
    assign overflow       = overflow_reg;
    assign char_count     = char_count_reg;

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
Controls the PS/2 receive/validate/translate chain. Consumes each received scan-code byte together with the valido/iniciar/terminar/traduccion flags decoded from it. Filters break (F0) and extended (E0) sequences, and frames a typing session between the start key and the end key. Buffers the translated 7-bit characters in a first-word-fall-through FIFO for the downstream display/storage logic, and gates rx_en for backpressure.

Parameters:
FIFO_DEPTH, 8, character FIFO entries; must be a power of 2, minimum 2.
TIMEOUT_CYCLES, 1_000_000, clk cycles the block waits in a prefix state before abandoning the prefix (about 20 ms at 50 MHz).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
rx_done_tick  in  1  one-cycle pulse from the receiver: scan_code and the decode flags are valid this cycle.
scan_code  in  8  received byte.
valido  in  1  byte is a translatable key, qualified by rx_done_tick.
iniciar  in  1  byte is the session-start key.
terminar  in  1  byte is the session-end key.
traduccion  in  7  translated character.
rx_en  out  1  receiver enable.
char_out  out  7  FIFO head; valid while char_empty=0.
char_empty  out  1  FIFO empty.
char_full  out  1  FIFO full.
char_rd  in  1  pop the FIFO head.
session_active  out  1  high while a session is open.
session_done  out  1  one-cycle pulse when a session closes.
overflow  out  1  sticky: a character was dropped.
char_count  out  8  characters pushed in the current session, saturating at 255.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, FIFO pointers cleared.
  - Output values during reset: char_empty=1, char_full=0, char_out=0, session_active=0, session_done=0, overflow=0, char_count=0, rx_en=0.
  - After reset release: rx_en = ~char_full.
- The state machine advances only on rx_done_tick, except for the timeouts and the DONE exit.
- States:
  - IDLE:
    - scan_code=F0 -> BRK_I.
    - iniciar=1 -> ACTIVE; on the same edge flush the FIFO, clear char_count and clear overflow.
    - Any other byte is ignored.
  - BRK_I: next tick is consumed with no action -> IDLE. Timeout -> IDLE.
  - ACTIVE (session_active=1). Priority order:
    - scan_code=F0 -> BRK_A.
    - scan_code=E0 -> EXT.
    - terminar=1 -> DONE.
    - iniciar=1 -> ignored; no restart.
    - valido=1 -> push traduccion and increment char_count.
    - Otherwise ignored.
  - BRK_A: next tick is consumed with no push (key release) -> ACTIVE. Timeout -> ACTIVE.
  - EXT:
    - Next byte F0 -> BRK_A.
    - Any other byte is consumed without push (extended keys are not translated) -> ACTIVE.
    - Timeout -> ACTIVE.
  - DONE: session_done=1 for exactly one cycle, session_active=0 -> IDLE unconditionally. FIFO contents are retained for readout.
- Timeout counter:
  - Cleared on entry to BRK_I, BRK_A or EXT, and on every tick.
  - Counts while in those states; expiry occurs when count reaches TIMEOUT_CYCLES-1.
- FIFO (FWFT):
  - A push on edge N is visible on char_out with char_empty=0 after edge N.
  - char_rd with char_empty=0 pops on the edge; char_rd while empty is ignored.
  - Push while full and no char_rd: character dropped, overflow set, char_count unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and char_rd in the same cycle while empty: push only.
  - Pointer width is log2(FIFO_DEPTH)+1 (extra wrap bit for the full/empty distinction).
- rx_en drops the cycle after char_full rises. Bytes already in flight are still processed and may set overflow.
- Reset asserted mid-session or mid-prefix: immediate return to the reset values; no session_done pulse.

Test Plan:
- Basic session: tick with iniciar=1, then tick 1C with valido=1 and traduccion=41, then tick F0, then tick 1C, then tick with terminar=1 -> exactly one entry 41; char_count=1; session_done is high for 1 cycle; session_active returns to 0.
- Extended/prefix filtering: in ACTIVE, send E0, 75, then E0, F0, 75 -> no push, state returns to ACTIVE. Separately, send F0 then no tick for TIMEOUT_CYCLES -> state returns to ACTIVE; the next valido byte pushes.
- Overflow: with FIFO_DEPTH=8, push 9 characters with char_rd=0 -> char_full=1, rx_en=0, overflow=1, char_count=8, the first 8 characters are read back in order. A new iniciar then clears overflow.
- Simultaneous events: push on the same cycle as char_rd with the FIFO full -> no overflow, count unchanged at full. The same with the FIFO empty -> char_empty=0 afterwards and char_out equals the pushed value.
- Idle filtering: in IDLE, send valido bytes, then F0 followed by the start code -> no push, still IDLE; a subsequent iniciar tick -> ACTIVE.
- Reset mid-session: assert reset=0 asynchronously between clock edges while in ACTIVE with 3 entries -> all outputs take reset values immediately; char_empty=1; no session_done pulse.
